// File: rtl/fetch_pkg.sv
// Shared fetch types: parcel kinds, RVC length mask and counter-width helper.
// Purely combinational definitions; no latency.
// No flow control of its own.
package fetch_pkg;

    localparam int         XLEN     = 32;
    localparam logic [1:0] RVC_MASK = 2'b11;

    typedef enum logic [1:0] {
        PARCEL_C_LO,
        PARCEL_W,
        PARCEL_C_HI,
        PARCEL_SPLIT
    } parcel_kind_e;

    // Width able to hold the values 0..n inclusive (CNT_W = $clog2(DEPTH+1)).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fetch_word_fifo.sv
// Word queue with head/next peek for the parcel aligner.
// Push visible at head one cycle later; pop takes effect at the clock edge.
// No internal backpressure: the issuer's credit accounting keeps it from overflowing.
module fetch_word_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = XLEN,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [WIDTH-1:0] next_dat_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_dat_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    assign head_dat_o = mem_q[rd_ptr_q];
    assign next_dat_o = mem_q[rd_ptr_q + PTR_W'(1)];
    assign count_o    = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch: credit-limited bus issue, word queue, 16/32-bit parcel aligner (FETCH_QUEUE_COMPRESSED_EN).
// Latency: >=1 cycle from bus response to instr_valid_o; outputs combinational from queue state.
// Backpressure: instr_ready_i low holds instr_o/pc_o; issue stalls once queue + in-flight reach DEPTH.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS    = 32'h0000_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] redirect_addr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        is_compressed_o,
    output logic        instruction_request_o,
    output logic [31:0] instruction_addr_o,
    input  logic        instruction_response_i,
    input  logic [31:0] instruction_data_i,
    output logic        flush_bus_o
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int OUT_W = cnt_width(MAX_OUTSTANDING);

`ifdef FETCH_QUEUE_COMPRESSED_EN
    localparam logic [31:0] BOOT_PC   = BOOT_ADDRESS;
    localparam logic        BOOT_HALF = BOOT_ADDRESS[1];
`else
    localparam logic [31:0] BOOT_PC   = {BOOT_ADDRESS[31:2], 2'b00};
    localparam logic        BOOT_HALF = 1'b0;
`endif

    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic [31:0]      out_pc_q, out_pc_d;
    logic             half_sel_q, half_sel_d;
    logic [OUT_W-1:0] outstanding_q, outstanding_d;
    logic [OUT_W-1:0] drop_q, drop_d;

    logic [CNT_W-1:0] count;
    logic [31:0]      head_dat, next_dat;
    logic [31:0]      redirect_pc;
    logic             redirect_half;
    logic [OUT_W-1:0] live_inflight;
    logic             issue, push, pop, xfer, present, compressed;
    logic [31:0]      instr;
    parcel_kind_e     kind;
    logic             unused_bits;

`ifdef FETCH_QUEUE_COMPRESSED_EN
    assign redirect_pc   = {redirect_addr_i[31:1], 1'b0};
    assign redirect_half = redirect_addr_i[1];
    assign unused_bits   = ^{redirect_addr_i[0], next_dat[31:16]};
`else
    assign redirect_pc   = {redirect_addr_i[31:2], 2'b00};
    assign redirect_half = 1'b0;
    assign unused_bits   = ^{redirect_addr_i[1:0], next_dat, half_sel_q};
`endif

    // A response landing in the flush cycle is already consumed, so it is not counted as stale.
    assign live_inflight = outstanding_q - OUT_W'(instruction_response_i);

    assign issue = !rst && !flush_i
                && (outstanding_q < OUT_W'(MAX_OUTSTANDING))
                && (int'(count) + int'(outstanding_q) < DEPTH);
    assign push  = instruction_response_i && (drop_q == '0) && !flush_i;

    always_comb begin
        kind       = PARCEL_W;
        instr      = head_dat;
        compressed = 1'b0;
        present    = (count != '0);
`ifdef FETCH_QUEUE_COMPRESSED_EN
        if (!half_sel_q) begin
            if (head_dat[1:0] != RVC_MASK) begin
                kind       = PARCEL_C_LO;
                instr      = {16'h0000, head_dat[15:0]};
                compressed = 1'b1;
            end
        end else if (head_dat[17:16] != RVC_MASK) begin
            kind       = PARCEL_C_HI;
            instr      = {16'h0000, head_dat[31:16]};
            compressed = 1'b1;
        end else begin
            kind    = PARCEL_SPLIT;
            instr   = {next_dat[15:0], head_dat[31:16]};
            present = (count >= CNT_W'(2));
        end
`endif
    end

    assign instr_valid_o   = !rst && !flush_i && present;
    assign xfer            = instr_valid_o && instr_ready_i;
    assign pop             = xfer && (kind != PARCEL_C_LO);
    assign instr_o         = instr_valid_o ? instr : 32'h0;
    assign is_compressed_o = instr_valid_o && compressed;
    assign pc_o            = rst ? 32'h0 : out_pc_q;

    assign instruction_request_o = issue;
    assign instruction_addr_o    = issue ? fetch_addr_q : 32'h0;
    assign flush_bus_o           = !rst && flush_i && (live_inflight != '0);

    always_comb begin
        fetch_addr_d  = fetch_addr_q;
        out_pc_d      = out_pc_q;
        half_sel_d    = half_sel_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + OUT_W'(issue) - OUT_W'(instruction_response_i);
        if (flush_i) begin
            fetch_addr_d = {redirect_addr_i[31:2], 2'b00};
            out_pc_d     = redirect_pc;
            half_sel_d   = redirect_half;
            drop_d       = live_inflight;
        end else begin
            if (instruction_response_i && (drop_q != '0)) begin
                drop_d = drop_q - OUT_W'(1);
            end
            if (issue) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
            end
            if (xfer) begin
                out_pc_d = out_pc_q + (compressed ? 32'd2 : 32'd4);
                case (kind)
                    PARCEL_C_LO:  half_sel_d = 1'b1;
                    PARCEL_C_HI:  half_sel_d = 1'b0;
                    PARCEL_SPLIT: half_sel_d = 1'b1;
                    default:      half_sel_d = half_sel_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_addr_q  <= {BOOT_ADDRESS[31:2], 2'b00};
            out_pc_q      <= BOOT_PC;
            half_sel_q    <= BOOT_HALF;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            out_pc_q      <= out_pc_d;
            half_sel_q    <= half_sel_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_word_fifo (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (flush_i),
        .push_i     (push),
        .push_dat_i (instruction_data_i),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .next_dat_o (next_dat),
        .count_o    (count)
    );

endmodule
